// File: rtl/ntsc_timing_pkg.sv
// Shared constants and types for the NTSC 240p timing generator.
// Holds the default raster timing, counter widths and the idle output set.
package ntsc_timing_pkg;

    localparam int unsigned HW = 10;
    localparam int unsigned VW = 9;

    localparam int unsigned NTSC_DIV           = 1;
    localparam int unsigned NTSC_H_TOTAL       = 910;
    localparam int unsigned NTSC_H_SYNC        = 67;
    localparam int unsigned NTSC_H_BURST_START = 76;
    localparam int unsigned NTSC_H_BURST_LEN   = 36;
    localparam int unsigned NTSC_H_ACT_START   = 150;
    localparam int unsigned NTSC_H_ACT_LEN     = 720;
    localparam int unsigned NTSC_V_TOTAL       = 262;
    localparam int unsigned NTSC_V_SYNC_START  = 3;
    localparam int unsigned NTSC_V_SYNC_LEN    = 3;
    localparam int unsigned NTSC_V_ACT_START   = 21;
    localparam int unsigned NTSC_V_ACT_LEN     = 240;

    typedef struct packed {
        logic          ck_ee;
        logic          xsync;
        logic          blank;
        logic          burst;
        logic          act;
        logic [HW-1:0] hcnt;
        logic [VW-1:0] vcnt;
        logic [HW-1:0] pix_x;
        logic          frame;
    } timing_out_t;

    localparam timing_out_t IDLE_OUT = '{
        ck_ee: 1'b0, xsync: 1'b1, blank: 1'b1, burst: 1'b0, act: 1'b0,
        hcnt: '0, vcnt: '0, pix_x: '0, frame: 1'b0
    };

    // Half-open window test [lo, lo+len), unsigned.
    function automatic logic in_range(input int unsigned x, input int unsigned lo,
                                      input int unsigned len);
        return (x >= lo) && (x < lo + len);
    endfunction

endpackage

// File: rtl/ntsc_ce_div.sv
// Pixel-tick divider: tick_c pulses on the last of every DIV enabled clocks.
module ntsc_ce_div #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_q;

    assign tick_c = en && (div_q == DW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (!en || tick_c) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/ntsc_timing_gen.sv
// NTSC 240p raster timing: H/V counters plus registered sync/blank/burst/active
// strobes, all updated together on each pixel tick.
module ntsc_timing_gen
    import ntsc_timing_pkg::*;
#(
    parameter int unsigned DIV           = NTSC_DIV,
    parameter int unsigned H_TOTAL       = NTSC_H_TOTAL,
    parameter int unsigned H_SYNC        = NTSC_H_SYNC,
    parameter int unsigned H_BURST_START = NTSC_H_BURST_START,
    parameter int unsigned H_BURST_LEN   = NTSC_H_BURST_LEN,
    parameter int unsigned H_ACT_START   = NTSC_H_ACT_START,
    parameter int unsigned H_ACT_LEN     = NTSC_H_ACT_LEN,
    parameter int unsigned V_TOTAL       = NTSC_V_TOTAL,
    parameter int unsigned V_SYNC_START  = NTSC_V_SYNC_START,
    parameter int unsigned V_SYNC_LEN    = NTSC_V_SYNC_LEN,
    parameter int unsigned V_ACT_START   = NTSC_V_ACT_START,
    parameter int unsigned V_ACT_LEN     = NTSC_V_ACT_LEN
) (
    input  logic          CK_i,
    input  logic          XAR_i,
    input  logic          EN_i,
    output logic          CK_EE_o,
    output logic          XSYNC_o,
    output logic          BLANK_o,
    output logic          BURST_o,
    output logic          ACT_o,
    output logic [HW-1:0] HCNT_o,
    output logic [VW-1:0] VCNT_o,
    output logic [HW-1:0] PIX_X_o,
    output logic          FRAME_o
);

    logic          tick_c;
    timing_out_t   out_q;
    timing_out_t   out_d;
    logic          h_wrap;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          vsync_line;
    logic          act_nxt;

    ntsc_ce_div #(.DIV(DIV)) u_ce_div (
        .clk    (CK_i),
        .rst_n  (XAR_i),
        .en     (EN_i),
        .tick_c (tick_c)
    );

    // Next raster position and its decode; the register stores the counters
    // so the flags always describe the H/V presented alongside them.
    always_comb begin
        h_wrap = (out_q.hcnt == HW'(H_TOTAL - 1));
        h_nxt  = h_wrap ? '0 : out_q.hcnt + HW'(1);
        v_nxt  = out_q.vcnt;
        if (h_wrap) begin
            v_nxt = (out_q.vcnt == VW'(V_TOTAL - 1)) ? '0 : out_q.vcnt + VW'(1);
        end
        vsync_line = in_range(32'(v_nxt), V_SYNC_START, V_SYNC_LEN);
        act_nxt    = in_range(32'(h_nxt), H_ACT_START, H_ACT_LEN)
                  && in_range(32'(v_nxt), V_ACT_START, V_ACT_LEN);

        out_d       = out_q;
        out_d.ck_ee = 1'b0;
        if (!EN_i) begin
            out_d = IDLE_OUT;
        end else if (tick_c) begin
            out_d.ck_ee = 1'b1;
            out_d.hcnt  = h_nxt;
            out_d.vcnt  = v_nxt;
            out_d.xsync = vsync_line ? (32'(h_nxt) >= H_TOTAL - H_SYNC)
                                     : (32'(h_nxt) >= H_SYNC);
            out_d.burst = !vsync_line && in_range(32'(h_nxt), H_BURST_START, H_BURST_LEN);
            out_d.act   = act_nxt;
            out_d.blank = !act_nxt;
            out_d.pix_x = act_nxt ? h_nxt - HW'(H_ACT_START) : '0;
            out_d.frame = (h_nxt == '0) && (v_nxt == '0);
        end
    end

    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            out_q <= IDLE_OUT;
        end else begin
            out_q <= out_d;
        end
    end

    assign CK_EE_o = out_q.ck_ee;
    assign XSYNC_o = out_q.xsync;
    assign BLANK_o = out_q.blank;
    assign BURST_o = out_q.burst;
    assign ACT_o   = out_q.act;
    assign HCNT_o  = out_q.hcnt;
    assign VCNT_o  = out_q.vcnt;
    assign PIX_X_o = out_q.pix_x;
    assign FRAME_o = out_q.frame;

`ifndef SYNTHESIS
    always @(posedge CK_i) begin
        param_check: assert (DIV >= 1
                          && H_ACT_START + H_ACT_LEN <= H_TOTAL
                          && V_ACT_START + V_ACT_LEN <= V_TOTAL
                          && H_BURST_START + H_BURST_LEN <= H_ACT_START
                          && H_TOTAL <= (1 << HW) && V_TOTAL <= (1 << VW))
            else $error("ntsc_timing_gen: inconsistent timing parameters");
    end
`endif

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Bench for ntsc_timing_gen: full-size raster at DIV=1 plus a shrunken raster
// at DIV=4 for frame wrap, reset, enable drop/restart and random enables.
module tb_ntsc_timing_gen;

    typedef struct packed {
        int div; int ht; int hs; int bs; int bl; int ast; int al;
        int vt;  int vs; int vsl; int vas; int val;
    } tcfg_t;

    localparam tcfg_t CFG_A = '{div: 1, ht: 910, hs: 67, bs: 76, bl: 36, ast: 150, al: 720,
                                vt: 262, vs: 3, vsl: 3, vas: 21, val: 240};
    localparam tcfg_t CFG_B = '{div: 4, ht: 64, hs: 5, bs: 7, bl: 6, ast: 16, al: 40,
                                vt: 20, vs: 3, vsl: 3, vas: 8, val: 10};
    localparam logic [34:0] IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 10'd0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0, rst_b_n = 1'b0, en_a = 1'b0, en_b = 1'b0;
    logic ck_ee_a, xsync_a, blank_a, burst_a, act_a, frame_a;
    logic ck_ee_b, xsync_b, blank_b, burst_b, act_b, frame_b;
    logic [9:0] hcnt_a, pix_a, hcnt_b, pix_b;
    logic [8:0] vcnt_a, vcnt_b;
    logic [34:0] obs_a, obs_b;

    int errors = 0;
    int checks = 0;
    longint e_a = 0;
    longint e_b = 0;

    ntsc_timing_gen #(.DIV(1)) dut_a (
        .CK_i(clk), .XAR_i(rst_a_n), .EN_i(en_a),
        .CK_EE_o(ck_ee_a), .XSYNC_o(xsync_a), .BLANK_o(blank_a), .BURST_o(burst_a),
        .ACT_o(act_a), .HCNT_o(hcnt_a), .VCNT_o(vcnt_a), .PIX_X_o(pix_a), .FRAME_o(frame_a)
    );

    ntsc_timing_gen #(
        .DIV(4), .H_TOTAL(64), .H_SYNC(5), .H_BURST_START(7), .H_BURST_LEN(6),
        .H_ACT_START(16), .H_ACT_LEN(40), .V_TOTAL(20), .V_SYNC_START(3),
        .V_SYNC_LEN(3), .V_ACT_START(8), .V_ACT_LEN(10)
    ) dut_b (
        .CK_i(clk), .XAR_i(rst_b_n), .EN_i(en_b),
        .CK_EE_o(ck_ee_b), .XSYNC_o(xsync_b), .BLANK_o(blank_b), .BURST_o(burst_b),
        .ACT_o(act_b), .HCNT_o(hcnt_b), .VCNT_o(vcnt_b), .PIX_X_o(pix_b), .FRAME_o(frame_b)
    );

    assign obs_a = {ck_ee_a, xsync_a, blank_a, burst_a, act_a, hcnt_a, vcnt_a, pix_a, frame_a};
    assign obs_b = {ck_ee_b, xsync_b, blank_b, burst_b, act_b, hcnt_b, vcnt_b, pix_b, frame_b};

    // Enabled clock edges since the last reset or idle edge.
    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) e_a <= 0;
        else          e_a <= en_a ? e_a + 1 : 0;
    end
    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) e_b <= 0;
        else          e_b <= en_b ? e_b + 1 : 0;
    end

    // Expected outputs from the tick index: n ticks since enable place the beam
    // at h = n mod H_TOTAL on line (n div H_TOTAL) mod V_TOTAL.
    function automatic logic [34:0] exp_vec(input tcfg_t c, input longint e);
        longint n, h, v;
        logic ck, vl, xs, bu, ac, fr;
        logic [9:0] px;
        ck = (e > 0) && (e % c.div == 0);
        n  = e / c.div;
        if (n == 0) return {ck, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 10'd0, 1'b0};
        h  = n % c.ht;
        v  = (n / c.ht) % c.vt;
        vl = (v >= c.vs) && (v < c.vs + c.vsl);
        xs = vl ? (h >= c.ht - c.hs) : (h >= c.hs);
        bu = !vl && (h >= c.bs) && (h < c.bs + c.bl);
        ac = (h >= c.ast) && (h < c.ast + c.al) && (v >= c.vas) && (v < c.vas + c.val);
        px = ac ? 10'(h - c.ast) : 10'd0;
        fr = (h == 0) && (v == 0);
        return {ck, xs, !ac, bu, ac, 10'(h), 9'(v), px, fr};
    endfunction

    task automatic test_reset();
        logic [34:0] exp;
        rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);
        exp = IDLE;
        if (obs_a !== exp) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp); end
        checks++;
        if (obs_b !== exp) begin errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp); end
        checks++;
        en_a = 1'b1; en_b = 1'b1;
        repeat (2) @(negedge clk);
        if (obs_a !== exp) begin errors++; $display("FAIL reset_en_a got=%h exp=%h", obs_a, exp); end
        checks++;
        if (obs_b !== exp) begin errors++; $display("FAIL reset_en_b got=%h exp=%h", obs_b, exp); end
        checks++;
        en_a = 1'b0; en_b = 1'b0;
    endtask

    task automatic test_line0();
        logic [34:0] exp;
        int samples = 0, sync_lo = 0, bursts = 0, blanks = 0, ck_lo = 0;
        rst_a_n = 1'b1; en_a = 1'b1;
        for (int i = 0; i < 1820; i++) begin
            @(negedge clk);
            exp = exp_vec(CFG_A, e_a);
            if (obs_a !== exp) begin errors++; $display("FAIL line0 e=%0d got=%h exp=%h", e_a, obs_a, exp); end
            checks++;
            if (!ck_ee_a) ck_lo++;
            if (vcnt_a == 9'd1) begin
                samples++;
                if (!xsync_a) sync_lo++;
                if (burst_a) bursts++;
                if (blank_a) blanks++;
            end
        end
        if (ck_lo !== 0) begin errors++; $display("FAIL ck_ee_steady got=%0d exp=0", ck_lo); end
        checks++;
        if (samples !== 910) begin errors++; $display("FAIL line_len got=%0d exp=910", samples); end
        checks++;
        if (sync_lo !== 67) begin errors++; $display("FAIL hsync_width got=%0d exp=67", sync_lo); end
        checks++;
        if (bursts !== 36) begin errors++; $display("FAIL burst_width got=%0d exp=36", bursts); end
        checks++;
        if (blanks !== 910) begin errors++; $display("FAIL blank_line got=%0d exp=910", blanks); end
        checks++;
    endtask

    task automatic test_vsync();
        logic [34:0] exp;
        int samples = 0, sync_lo = 0, bursts = 0;
        int n = 5460 - int'(e_a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp = exp_vec(CFG_A, e_a);
            if (obs_a !== exp) begin errors++; $display("FAIL vsync e=%0d got=%h exp=%h", e_a, obs_a, exp); end
            checks++;
            if (vcnt_a >= 9'd3 && vcnt_a <= 9'd5) begin
                samples++;
                if (!xsync_a) sync_lo++;
                if (burst_a) bursts++;
            end
        end
        if (samples !== 2730) begin errors++; $display("FAIL vsync_lines got=%0d exp=2730", samples); end
        checks++;
        if (sync_lo !== 2529) begin errors++; $display("FAIL broad_pulse got=%0d exp=2529", sync_lo); end
        checks++;
        if (bursts !== 0) begin errors++; $display("FAIL vsync_burst got=%0d exp=0", bursts); end
        checks++;
    endtask

    task automatic test_active();
        logic [34:0] exp;
        int acts = 0, blanks = 0, first_h = -1, pix_max = -1;
        int n = 20020 - int'(e_a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp = exp_vec(CFG_A, e_a);
            if (obs_a !== exp) begin errors++; $display("FAIL active e=%0d got=%h exp=%h", e_a, obs_a, exp); end
            checks++;
            if (vcnt_a == 9'd21) begin
                if (blank_a) blanks++;
                if (act_a) begin
                    acts++;
                    if (first_h < 0) first_h = int'(hcnt_a);
                    if (int'(pix_a) > pix_max) pix_max = int'(pix_a);
                end
            end
        end
        if (acts !== 720) begin errors++; $display("FAIL act_width got=%0d exp=720", acts); end
        checks++;
        if (blanks !== 190) begin errors++; $display("FAIL act_blank got=%0d exp=190", blanks); end
        checks++;
        if (first_h !== 150) begin errors++; $display("FAIL act_start got=%0d exp=150", first_h); end
        checks++;
        if (pix_max !== 719) begin errors++; $display("FAIL pix_max got=%0d exp=719", pix_max); end
        checks++;
        en_a = 1'b0;
        @(negedge clk);
        if (obs_a !== IDLE) begin errors++; $display("FAIL en_drop_a got=%h exp=%h", obs_a, IDLE); end
        checks++;
    endtask

    task automatic test_frame_wrap();
        logic [34:0] exp, prev;
        int ticks = 0, f1 = -1, f2 = -1, frame_cyc = 0, l19 = 0, l19_act = 0, off_tick = 0;
        rst_b_n = 1'b1; en_b = 1'b1;
        prev = obs_b;
        for (int i = 0; i < 10400; i++) begin
            @(negedge clk);
            exp = exp_vec(CFG_B, e_b);
            if (obs_b !== exp) begin errors++; $display("FAIL frame e=%0d got=%h exp=%h", e_b, obs_b, exp); end
            checks++;
            if (!ck_ee_b && (obs_b[33:0] !== prev[33:0])) off_tick++;
            prev = obs_b;
            if (ck_ee_b) begin
                ticks++;
                if (frame_b) begin
                    if (f1 < 0) f1 = ticks;
                    else if (f2 < 0) f2 = ticks;
                end
            end
            if (frame_b) frame_cyc++;
            if (vcnt_b == 9'd19) begin
                l19++;
                if (act_b) l19_act++;
            end
        end
        if (f1 !== 1280) begin errors++; $display("FAIL first_frame got=%0d exp=1280", f1); end
        checks++;
        if (f2 - f1 !== 1280) begin errors++; $display("FAIL frame_period got=%0d exp=1280", f2 - f1); end
        checks++;
        if (frame_cyc !== 8) begin errors++; $display("FAIL frame_width got=%0d exp=8", frame_cyc); end
        checks++;
        if (off_tick !== 0) begin errors++; $display("FAIL change_off_tick got=%0d exp=0", off_tick); end
        checks++;
        if (l19 !== 512 || l19_act !== 0) begin
            errors++; $display("FAIL last_line got=%0d/%0d exp=512/0", l19, l19_act);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [34:0] exp;
        for (int k = 0; k < 3; k++) begin
            int r = int'($urandom_range(100, 3000));
            for (int i = 0; i < r; i++) begin
                @(negedge clk);
                exp = exp_vec(CFG_B, e_b);
                if (obs_b !== exp) begin errors++; $display("FAIL rst_run e=%0d got=%h exp=%h", e_b, obs_b, exp); end
                checks++;
            end
            @(posedge clk);
            #2 rst_b_n = 1'b0;
            #1;
            if (obs_b !== IDLE) begin errors++; $display("FAIL rst_mid got=%h exp=%h", obs_b, IDLE); end
            checks++;
            @(negedge clk);
            rst_b_n = 1'b1;
        end
    endtask

    task automatic test_en_restart();
        logic [34:0] exp;
        for (int k = 0; k < 3; k++) begin
            int r = int'($urandom_range(100, 3000));
            for (int i = 0; i < r; i++) begin
                @(negedge clk);
                exp = exp_vec(CFG_B, e_b);
                if (obs_b !== exp) begin errors++; $display("FAIL en_run e=%0d got=%h exp=%h", e_b, obs_b, exp); end
                checks++;
            end
            en_b = 1'b0;
            @(negedge clk);
            if (obs_b !== IDLE) begin errors++; $display("FAIL en_drop got=%h exp=%h", obs_b, IDLE); end
            checks++;
            en_b = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                exp = (c < 4) ? IDLE : {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 9'd0, 10'd0, 1'b0};
                if (obs_b !== exp) begin
                    errors++; $display("FAIL restart clk=%0d got=%h exp=%h", c, obs_b, exp);
                end
                checks++;
            end
        end
    endtask

    task automatic test_random_en();
        logic [34:0] exp;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            exp = exp_vec(CFG_B, e_b);
            if (obs_b !== exp) begin errors++; $display("FAIL rand_en e=%0d got=%h exp=%h", e_b, obs_b, exp); end
            checks++;
            en_b = ($urandom_range(0, 7) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_line0();
        test_vsync();
        test_active();
        test_frame_wrap();
        test_reset_mid();
        test_en_restart();
        test_random_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntsc_timing_gen.md
Name: ntsc_timing_gen

Overview:
- Timing controller that sequences the tiny NTSC luma encoder.
- Generates the pixel-rate clock enable plus the sync, blank and burst control strobes the encoder consumes.
- Supplies the pixel/line counters and an active-video request to the character generator feeding luma.
- Sits between the system clock domain and the encoder. Non-interlaced 262-line (240p) frame.

Parameters:
- DIV, 1, system clocks per pixel tick; DIV >= 1; DIV=1 means a tick every clock.
- H_TOTAL, 910, pixel ticks per line (4fsc).
- H_SYNC, 67, horizontal sync width in ticks.
- H_BURST_START, 76, first burst tick of the line.
- H_BURST_LEN, 36, burst width in ticks.
- H_ACT_START, 150, first active pixel of the line.
- H_ACT_LEN, 720, active pixels per line.
- V_TOTAL, 262, lines per frame.
- V_SYNC_START, 3, first vertical-sync line.
- V_SYNC_LEN, 3, vertical-sync lines.
- V_ACT_START, 21, first active line.
- V_ACT_LEN, 240, active lines.

Ports:
- CK_i, in, 1, system clock.
- XAR_i, in, 1, asynchronous active-low reset.
- EN_i, in, 1, run enable; 0 = idle.
- CK_EE_o, out, 1, pixel clock enable to encoder.
- XSYNC_o, out, 1, composite sync; 0 = sync tip.
- BLANK_o, out, 1, 1 = blanking.
- BURST_o, out, 1, 1 = burst window.
- ACT_o, out, 1, active-pixel request to luma source.
- HCNT_o, out, 10, horizontal tick count, 0..H_TOTAL-1.
- VCNT_o, out, 9, line count, 0..V_TOTAL-1.
- PIX_X_o, out, 10, HCNT_o-H_ACT_START when ACT_o, else 0.
- FRAME_o, out, 1, frame-start flag (HCNT=0, VCNT=0).

Behaviour:
- Reset (XAR_i=0, asynchronous):
  - divider=0, H=0, V=0.
  - CK_EE_o=0, XSYNC_o=1, BLANK_o=1, BURST_o=0, ACT_o=0, PIX_X_o=0, FRAME_o=0.
- Tick generation:
  - The divider counts 0..DIV-1 while EN_i=1. Internal tick t=1 when divider==DIV-1; the divider then wraps to 0.
  - DIV=1: t=1 on every clock while EN_i=1.
- Counter update:
  - On the clock edge where t=1, H increments; at H_TOTAL-1 it wraps to 0 and V increments; at V_TOTAL-1, V wraps to 0.
  - All decoded outputs are registered on the same edge and are coherent with the new H/V.
- CK_EE_o:
  - Registered copy of t, so it is high for exactly one CK in the cycle after the update.
  - Flags are stable throughout every CK_EE_o=1 cycle. With DIV=1 and EN_i=1, CK_EE_o is constant 1.
- Decode, with H/V the new values:
  - vsync_line = V in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN).
  - Normal line: XSYNC_o=0 iff H < H_SYNC.
  - vsync_line (broad pulse): XSYNC_o=0 iff H < H_TOTAL-H_SYNC.
  - BURST_o = !vsync_line AND H in [H_BURST_START, H_BURST_START+H_BURST_LEN).
  - ACT_o = H in [H_ACT_START, H_ACT_START+H_ACT_LEN) AND V in [V_ACT_START, V_ACT_START+V_ACT_LEN).
  - BLANK_o = !ACT_o.
  - FRAME_o = (H==0 AND V==0); high for exactly one tick period.
- EN_i=0, synchronous: on the next edge divider, H and V clear to 0 and outputs go to their reset values.
- EN_i 0->1 restart:
  - The first tick occurs DIV clocks after EN_i rises and produces H=1, V=0.
  - FRAME_o is first asserted at the next H=0, V=0.
- Width rules:
  - H and V compare as unsigned.
  - Parameter consistency required: H_ACT_START+H_ACT_LEN <= H_TOTAL, V_ACT_START+V_ACT_LEN <= V_TOTAL, and the burst window ends before H_ACT_START. Violations are flagged by a simulation-only assertion; no hardware check.
- Simultaneous H wrap and V wrap in one tick: both counters wrap, FRAME_o=1 on that same edge.
- Reset mid-line: immediate return to reset values. No partial-line completion.

Decomposition:
- Package ntsc_timing_pkg holds:
  - default timing constants (the H_* and V_* values above);
  - counter widths (HW=10, VW=9);
  - the idle output value set.
- One natural sub-module: ntsc_ce_div, the DIV divider producing t. Decode and counters stay in the top module.

Test Plan:
- Reset then EN_i=1, DIV=1 -> CK_EE_o=1 steady; XSYNC_o=0 for HCNT 0..66; BURST_o=1 for HCNT 76..111 on line 0; BLANK_o=1 throughout line 0.
- Run to VCNT=3..5 -> XSYNC_o=0 for HCNT 0..842, 1 for 843..909; BURST_o never 1 on those lines.
- VCNT=21 -> ACT_o=1, BLANK_o=0 for HCNT 150..869; PIX_X_o ramps 0..719. VCNT=261 -> ACT_o=0 on the whole line.
- Frame wrap at HCNT=909, VCNT=261 -> next tick gives HCNT=0, VCNT=0, FRAME_o=1 for one tick; period 910*262 ticks between FRAME_o pulses.
- DIV=4 -> CK_EE_o high 1 of every 4 CK; HCNT_o and flags change only on the edge before each CK_EE_o pulse.
- XAR_i low at HCNT=400, VCNT=100 -> all outputs to reset values immediately. EN_i dropped mid-line -> idle on the next edge. Restart -> HCNT_o=1 after DIV clocks.
